// File: rtl/mio_bus_pkg.sv
// Shared types and constants for the MIO bus bridge: FSM state encoding,
// default slot base table and timeout-counter sizing.
package mio_bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } mio_state_e;

  // slot0=0x0 (RAM), slot1=0xE, slot2=0xF, slot3=0xD
  localparam logic [15:0] MIO_SLOT_BASE_DEFAULT = 16'hDFE0;

  function automatic int unsigned mio_tmo_cnt_w(input int unsigned timeout);
    return (timeout == 0) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/mio_bus_if.sv
// CPU data port plus peripheral slot bus. 'slave' is the bridge's view,
// 'master' is the CPU/peripheral environment driving requests and acks.
interface mio_bus_if #(
  parameter int unsigned NSLOT = 4,
  parameter int unsigned AW    = 32,
  parameter int unsigned DW    = 32
);
  logic                cpu_req;
  logic                cpu_we;
  logic [AW-1:0]       cpu_addr;
  logic [DW-1:0]       cpu_wdata;
  logic [DW-1:0]       cpu_rdata;
  logic                cpu_ready;
  logic                cpu_err;
  logic [NSLOT-1:0]    slv_sel;
  logic                slv_we;
  logic [AW-1:0]       slv_addr;
  logic [DW-1:0]       slv_wdata;
  logic [NSLOT*DW-1:0] slv_rdata;
  logic [NSLOT-1:0]    slv_ack;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, slv_rdata, slv_ack,
    output cpu_rdata, cpu_ready, cpu_err, slv_sel, slv_we, slv_addr, slv_wdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, slv_rdata, slv_ack,
    input  cpu_rdata, cpu_ready, cpu_err, slv_sel, slv_we, slv_addr, slv_wdata
  );
endinterface

// File: rtl/mio_bus_decode.sv
// Combinational address-tag to one-hot slot decode; lowest matching slot wins.
module mio_bus_decode
  import mio_bus_pkg::*;
#(
  parameter int unsigned               NSLOT     = 4,
  parameter int unsigned               DEC_BITS  = 4,
  parameter logic [NSLOT*DEC_BITS-1:0] SLOT_BASE = MIO_SLOT_BASE_DEFAULT
) (
  input  logic [DEC_BITS-1:0] i_tag,
  output logic [NSLOT-1:0]    o_sel,
  output logic                o_hit
);

  always_comb begin
    o_sel = '0;
    o_hit = 1'b0;
    for (int unsigned i = 0; i < NSLOT; i++) begin
      if (!o_hit && (i_tag == SLOT_BASE[i*DEC_BITS +: DEC_BITS])) begin
        o_sel[i] = 1'b1;
        o_hit    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mio_bus_bridge.sv
// Memory-mapped I/O bridge: CPU request/ready port to NSLOT wait-stated slots.
// Define MIO_BUS_TIMEOUT_EN to abort slot accesses after TIMEOUT cycles.
module mio_bus_bridge
  import mio_bus_pkg::*;
#(
  parameter int unsigned               NSLOT     = 4,
  parameter int unsigned               AW        = 32,
  parameter int unsigned               DW        = 32,
  parameter int unsigned               DEC_BITS  = 4,
  parameter logic [NSLOT*DEC_BITS-1:0] SLOT_BASE = MIO_SLOT_BASE_DEFAULT,
  parameter int unsigned               TIMEOUT   = 15
) (
  input logic      clk,
  input logic      rst,
  mio_bus_if.slave bus
);

  if (NSLOT < 1 || NSLOT > 8 || DEC_BITS < 1 || DEC_BITS > AW || TIMEOUT < 1) begin : g_cfg_err
    $error("mio_bus_bridge: invalid parameter set");
  end

  mio_state_e       r_state;
  mio_state_e       w_state_n;
  logic [NSLOT-1:0] w_dec_sel;
  logic             w_dec_hit;
  logic             w_ack;
  logic             w_tmo;
  logic [DW-1:0]    w_slot_rdata;

  logic [NSLOT-1:0] r_sel;
  logic             r_we;
  logic [AW-1:0]    r_addr;
  logic [DW-1:0]    r_wdata;
  logic [DW-1:0]    r_rdata;
  logic             r_ready;
  logic             r_err;

  mio_bus_decode #(
    .NSLOT    (NSLOT),
    .DEC_BITS (DEC_BITS),
    .SLOT_BASE(SLOT_BASE)
  ) u_decode (
    .i_tag(bus.cpu_addr[AW-1 -: DEC_BITS]),
    .o_sel(w_dec_sel),
    .o_hit(w_dec_hit)
  );

  // r_sel is one-hot in ACCESS, so the data mux reduces to a priority pick
  always_comb begin
    w_ack        = |(bus.slv_ack & r_sel);
    w_slot_rdata = '0;
    for (int unsigned i = 0; i < NSLOT; i++) begin
      if (r_sel[i]) w_slot_rdata = bus.slv_rdata[i*DW +: DW];
    end
  end

`ifdef MIO_BUS_TIMEOUT_EN
  localparam int unsigned TW = mio_tmo_cnt_w(TIMEOUT);
  logic [TW-1:0] r_tmo_cnt;

  // Counter holds the number of completed ACCESS cycles; the limit is hit
  // at the end of the TIMEOUT-th cycle, and an ack in that cycle wins.
  assign w_tmo = (r_state == ACCESS) && (r_tmo_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    r_tmo_cnt <= '0;
    else if (r_state != ACCESS) r_tmo_cnt <= '0;
    else                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
  end
`else
  assign w_tmo = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_n;
  end

  always_comb begin
    w_state_n = r_state;
    unique case (r_state)
      IDLE:    if (bus.cpu_req) w_state_n = w_dec_hit ? ACCESS : RESP;
      ACCESS:  if (w_ack || w_tmo) w_state_n = RESP;
      RESP:    w_state_n = IDLE;
      default: w_state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sel   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_ready <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_ready <= (w_state_n == RESP);
      unique case (r_state)
        IDLE: begin
          if (bus.cpu_req) begin
            r_addr  <= bus.cpu_addr;
            r_we    <= bus.cpu_we;
            r_wdata <= bus.cpu_wdata;
            r_sel   <= w_dec_sel;
            r_rdata <= '0;
            r_err   <= !w_dec_hit;
          end
        end
        ACCESS: begin
          if (w_ack) begin
            r_sel   <= '0;
            r_rdata <= r_we ? '0 : w_slot_rdata;
            r_err   <= 1'b0;
          end else if (w_tmo) begin
            r_sel   <= '0;
            r_rdata <= '0;
            r_err   <= 1'b1;
          end
        end
        RESP: begin
          r_sel <= '0;
          r_err <= 1'b0;
        end
        default: begin
          r_sel <= '0;
          r_err <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cpu_rdata = r_rdata;
  assign bus.cpu_ready = r_ready;
  assign bus.cpu_err   = r_err;
  assign bus.slv_sel   = r_sel;
  assign bus.slv_we    = r_we;
  assign bus.slv_addr  = r_addr;
  assign bus.slv_wdata = r_wdata;

endmodule
